tb_cpu_bus_master: RTL and testbench



---
 rtl/tb_cpu_bus_master.sv | 192 +++++++++++++++++++
 tb/tb_tb_cpu_bus_master.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tb_cpu_bus_master.sv
// Bench-side 68000-style bus master: queued read/write commands run as asynchronous
// CPU bus cycles paced by clk7_en, with results (or dtack timeouts) returned in order.
module tb_cpu_bus_master #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned WIDE    = 0
) (
    input  logic        clk_28,
    input  logic        reset_n,
    input  logic        clk7_en,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [23:0] cmd_addr,
    input  logic [3:0]  cmd_be,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_timeout,
    output logic [23:0] cpu_address,
    output logic [15:0] cpu_data_out,
    input  logic [15:0] cpu_data,
    input  logic [15:0] cpu_data2,
    output logic        cpu_as,
    output logic        cpu_uds,
    output logic        cpu_lds,
    output logic        cpu_uds2,
    output logic        cpu_lds2,
    output logic        cpu_r_w,
    input  logic        cpu_dtack,
    output logic        busy,
    output logic [7:0]  err_count
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef struct packed {
        logic        write;
        logic [23:0] addr;
        logic [3:0]  be;
        logic [15:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic        timeout;
        logic [31:0] rdata;
    } rsp_t;

    typedef enum logic [1:0] {IDLE, SETUP, WAIT, HOLD} state_t;

    state_t        state, state_d;
    cmd_t          cmd_mem [DEPTH];
    rsp_t          rsp_mem [DEPTH];
    cmd_t          cmd_head;
    rsp_t          rsp_head, rsp_hold;
    logic [PW-1:0] cmd_wr, cmd_rd, rsp_wr, rsp_rd;
    logic [CW-1:0] cmd_cnt, rsp_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [3:0]    cur_be;
    logic          cmd_full, cmd_empty, rsp_full, rsp_empty;
    logic          cmd_push, cmd_pop, rsp_push, rsp_pop;
    logic          cnt_clr, cnt_inc, dtack_hit, tmo_hit, drive;

    assign cmd_full  = cmd_cnt == CW'(DEPTH);
    assign cmd_empty = cmd_cnt == '0;
    assign rsp_full  = rsp_cnt == CW'(DEPTH);
    assign rsp_empty = rsp_cnt == '0;
    assign cmd_push  = cmd_valid && !cmd_full;
    assign rsp_pop   = !rsp_empty && rsp_ready;
    assign cmd_head  = cmd_mem[cmd_rd];
    assign rsp_head  = rsp_mem[rsp_rd];

    assign cmd_ready   = !cmd_full;
    assign rsp_valid   = !rsp_empty;
    assign rsp_rdata   = rsp_empty ? 32'h0 : rsp_head.rdata;
    assign rsp_timeout = rsp_empty ? 1'b0 : rsp_head.timeout;
    assign busy        = (state != IDLE) || !cmd_empty;

    // State register
    always_ff @(posedge clk_28 or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    // Next state: everything advances on clk7_en ticks only
    always_comb begin
        state_d = state;
        if (clk7_en) begin
            case (state)
                IDLE:    if (!cmd_empty && !rsp_full) state_d = SETUP;
                SETUP:   state_d = WAIT;
                WAIT:    if (!cpu_dtack || tmo_cnt == TW'(TIMEOUT - 1)) state_d = HOLD;
                HOLD:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Per-state controls; strobes are low exactly while the next state is WAIT
    always_comb begin
        cmd_pop   = 1'b0;
        rsp_push  = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        dtack_hit = 1'b0;
        tmo_hit   = 1'b0;
        drive     = (state_d == WAIT);
        if (clk7_en) begin
            case (state)
                IDLE:  cmd_pop = !cmd_empty && !rsp_full;
                SETUP: cnt_clr = 1'b1;
                WAIT: begin
                    if (!cpu_dtack)                          dtack_hit = 1'b1;
                    else if (tmo_cnt == TW'(TIMEOUT - 1))    tmo_hit   = 1'b1;
                    else                                     cnt_inc   = 1'b1;
                end
                HOLD:  rsp_push = 1'b1;
                default: ;
            endcase
        end
    end

    // Bus-side datapath and strobes
    always_ff @(posedge clk_28 or negedge reset_n) begin
        if (!reset_n) begin
            cpu_address  <= 24'h0;
            cpu_data_out <= 16'h0;
            cpu_r_w      <= 1'b1;
            cpu_as       <= 1'b1;
            cpu_uds      <= 1'b1;
            cpu_lds      <= 1'b1;
            cpu_uds2     <= 1'b1;
            cpu_lds2     <= 1'b1;
            cur_be       <= 4'h0;
            tmo_cnt      <= '0;
            rsp_hold     <= '0;
            err_count    <= 8'h0;
        end else begin
            if (cmd_pop) begin
                cpu_address  <= cmd_head.addr;
                cpu_r_w      <= !cmd_head.write;
                cpu_data_out <= cmd_head.wdata;
                cur_be       <= cmd_head.be;
            end
            if (clk7_en) begin
                cpu_as   <= !drive;
                cpu_uds  <= !(drive && cur_be[3]);
                cpu_lds  <= !(drive && cur_be[2]);
                cpu_uds2 <= !(drive && cur_be[1] && (WIDE != 0));
                cpu_lds2 <= !(drive && cur_be[0] && (WIDE != 0));
            end
            if (cnt_clr)      tmo_cnt <= '0;
            else if (cnt_inc) tmo_cnt <= tmo_cnt + TW'(1);
            if (dtack_hit) begin
                rsp_hold.timeout <= 1'b0;
                rsp_hold.rdata   <= cpu_r_w ? {cpu_data, (WIDE != 0) ? cpu_data2 : 16'h0} : 32'h0;
            end
            if (tmo_hit) begin
                rsp_hold <= '{timeout: 1'b1, rdata: 32'h0};
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
        end
    end

    // FIFO storage; entries beyond the counts are never observed
    always_ff @(posedge clk_28) begin
        if (cmd_push) cmd_mem[cmd_wr] <= '{write: cmd_write, addr: cmd_addr & 24'hFFFFFE,
                                           be: cmd_be, wdata: cmd_wdata};
        if (rsp_push) rsp_mem[rsp_wr] <= rsp_hold;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_28 or negedge reset_n) begin
        if (!reset_n) begin
            cmd_wr  <= '0;
            cmd_rd  <= '0;
            cmd_cnt <= '0;
            rsp_wr  <= '0;
            rsp_rd  <= '0;
            rsp_cnt <= '0;
        end else begin
            if (cmd_push) cmd_wr <= cmd_wr + PW'(1);
            if (cmd_pop)  cmd_rd <= cmd_rd + PW'(1);
            if (rsp_push) rsp_wr <= rsp_wr + PW'(1);
            if (rsp_pop)  rsp_rd <= rsp_rd + PW'(1);
            cmd_cnt <= cmd_cnt + CW'(cmd_push) - CW'(cmd_pop);
            rsp_cnt <= rsp_cnt + CW'(rsp_push) - CW'(rsp_pop);
        end
    end
endmodule

// File: tb/tb_tb_cpu_bus_master.sv
// Directed bench for tb_cpu_bus_master: a WIDE=1 and a WIDE=0 instance run in lockstep
// on shared stimulus against a bench dtack responder.
module tb_tb_cpu_bus_master;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 16;

    logic        clk_28 = 1'b0;
    logic        reset_n;
    logic [1:0]  en_cnt = 2'd0;
    logic        clk7_en;
    logic        cmd_valid, cmd_write, rsp_ready;
    logic [23:0] cmd_addr;
    logic [3:0]  cmd_be;
    logic [15:0] cmd_wdata;
    logic [15:0] cpu_data = 16'h0, cpu_data2 = 16'h0;
    logic        cpu_dtack = 1'b1;

    logic        w_cmd_ready, w_rsp_valid, w_rsp_timeout, w_as, w_uds, w_lds, w_uds2, w_lds2, w_r_w, w_busy;
    logic [31:0] w_rsp_rdata;
    logic [23:0] w_cpu_address;
    logic [15:0] w_cpu_data_out;
    logic [7:0]  w_err_count;
    logic        n_cmd_ready, n_rsp_valid, n_rsp_timeout, n_as, n_uds, n_lds, n_uds2, n_lds2, n_r_w, n_busy;
    logic [31:0] n_rsp_rdata;
    logic [23:0] n_cpu_address;
    logic [15:0] n_cpu_data_out;
    logic [7:0]  n_err_count;

    int checks = 0;
    int errors = 0;
    int dly = 0;
    int wt = 0;
    int as_low = 0, uds_low = 0, lds_low = 0, uds2_low = 0, lds2_low = 0, n_x2_low = 0, as_falls = 0;
    logic as_prev = 1'b1;

    tb_cpu_bus_master #(.DEPTH(DEPTH), .TIMEOUT(TMO), .WIDE(1)) u_wide (
        .clk_28(clk_28), .reset_n(reset_n), .clk7_en(clk7_en),
        .cmd_valid(cmd_valid), .cmd_ready(w_cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_be(cmd_be), .cmd_wdata(cmd_wdata),
        .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(w_rsp_rdata),
        .rsp_timeout(w_rsp_timeout), .cpu_address(w_cpu_address), .cpu_data_out(w_cpu_data_out),
        .cpu_data(cpu_data), .cpu_data2(cpu_data2), .cpu_as(w_as), .cpu_uds(w_uds),
        .cpu_lds(w_lds), .cpu_uds2(w_uds2), .cpu_lds2(w_lds2), .cpu_r_w(w_r_w),
        .cpu_dtack(cpu_dtack), .busy(w_busy), .err_count(w_err_count)
    );

    tb_cpu_bus_master #(.DEPTH(DEPTH), .TIMEOUT(TMO), .WIDE(0)) u_narrow (
        .clk_28(clk_28), .reset_n(reset_n), .clk7_en(clk7_en),
        .cmd_valid(cmd_valid), .cmd_ready(n_cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_be(cmd_be), .cmd_wdata(cmd_wdata),
        .rsp_valid(n_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(n_rsp_rdata),
        .rsp_timeout(n_rsp_timeout), .cpu_address(n_cpu_address), .cpu_data_out(n_cpu_data_out),
        .cpu_data(cpu_data), .cpu_data2(cpu_data2), .cpu_as(n_as), .cpu_uds(n_uds),
        .cpu_lds(n_lds), .cpu_uds2(n_uds2), .cpu_lds2(n_lds2), .cpu_r_w(n_r_w),
        .cpu_dtack(cpu_dtack), .busy(n_busy), .err_count(n_err_count)
    );

    always #5 clk_28 = ~clk_28;
    always @(posedge clk_28) en_cnt <= en_cnt + 2'd1;
    assign clk7_en = (en_cnt == 2'd3);

    // Responder: dtack goes low after dly WAIT ticks have seen it high; data follows the address
    always @(negedge clk_28) begin
        cpu_data  = w_cpu_address[15:0];
        cpu_data2 = w_cpu_address[15:0] + 16'h4444;
        if (w_as) begin
            wt = 0;
            cpu_dtack = 1'b1;
        end else begin
            cpu_dtack = !(wt >= dly);
            if (clk7_en) wt++;
        end
    end

    // Strobe-low clk28 counts and address-strobe assertions
    always @(negedge clk_28) begin
        if (!w_as)   as_low++;
        if (!w_uds)  uds_low++;
        if (!w_lds)  lds_low++;
        if (!w_uds2) uds2_low++;
        if (!w_lds2) lds2_low++;
        if (!n_uds2 || !n_lds2) n_x2_low++;
        if (as_prev && !w_as) as_falls++;
        as_prev = w_as;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic align_tick();
        int n = 0;
        while (!clk7_en && n < 8) begin @(negedge clk_28); n++; end
    endtask

    task automatic push(input logic wr, input logic [23:0] addr, input logic [3:0] be, input logic [15:0] wd);
        int n = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_be = be; cmd_wdata = wd;
        while (!w_cmd_ready && n < 500) begin @(negedge clk_28); n++; end
        if (!w_cmd_ready) check("push_wait", 32'(w_cmd_ready), 32'd1);
        @(negedge clk_28);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int limit);
        int n = 0;
        while (!w_rsp_valid && n < limit) begin @(negedge clk_28); n++; end
        if (!w_rsp_valid) check({tag, "_rsp_wait"}, 32'(w_rsp_valid), 32'd1);
    endtask

    task automatic pop(input string tag, input logic [31:0] ew, input logic [31:0] en, input logic et);
        wait_rsp(tag, 400);
        check({tag, "_wide_rdata"}, w_rsp_rdata, ew);
        check({tag, "_narrow_rdata"}, n_rsp_rdata, en);
        check({tag, "_timeout"}, 32'({w_rsp_timeout, n_rsp_timeout}), 32'({et, et}));
        rsp_ready = 1'b1;
        @(negedge clk_28);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int cyc, a0, u0, l0, u20, l20, n20, f0, n;
        logic saw_as;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 24'h0;
        cmd_be = 4'h0; cmd_wdata = 16'h0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk_28);

        // Reset state
        check("rst_w_strobes", 32'({w_as, w_uds, w_lds, w_uds2, w_lds2, w_r_w}), 32'h3F);
        check("rst_n_strobes", 32'({n_as, n_uds, n_lds, n_uds2, n_lds2, n_r_w}), 32'h3F);
        check("rst_addr", 32'(w_cpu_address | n_cpu_address), 32'h0);
        check("rst_wdata", 32'({w_cpu_data_out, n_cpu_data_out}), 32'h0);
        check("rst_flags", 32'({w_cmd_ready, n_cmd_ready, w_rsp_valid, n_rsp_valid,
                                w_rsp_timeout, n_rsp_timeout, w_busy, n_busy}), 32'hC0);
        check("rst_rdata", w_rsp_rdata | n_rsp_rdata, 32'h0);
        check("rst_err", 32'({w_err_count, n_err_count}), 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_28);

        // COLOR00 write, dtack on first WAIT tick
        dly = 0;
        align_tick();
        a0 = as_low; u0 = uds_low; l0 = lds_low; u20 = uds2_low; l20 = lds2_low; n20 = n_x2_low;
        push(1'b1, 24'hDFF180, 4'b1100, 16'h0F00);
        cyc = 0; saw_as = 1'b0;
        while (!w_rsp_valid && cyc < 100) begin
            if (!w_as && !saw_as) begin
                saw_as = 1'b1;
                check("t1_addr", 32'(w_cpu_address), 32'h00DFF180);
                check("t1_data_out", 32'(w_cpu_data_out), 32'h0F00);
                check("t1_r_w", 32'({w_r_w, n_r_w}), 32'h0);
            end
            @(negedge clk_28);
            cyc++;
        end
        check("t1_cycle_clk28", 32'(cyc), 32'd16);
        check("t1_as_low", 32'(as_low - a0), 32'd4);
        check("t1_uds_lds_low", 32'({16'(uds_low - u0), 16'(lds_low - l0)}), 32'h00040004);
        check("t1_x2_low", 32'((uds2_low - u20) + (lds2_low - l20) + (n_x2_low - n20)), 32'd0);
        pop("t1", 32'h0, 32'h0, 1'b0);

        // Wide read with dtack delayed 3 ticks
        dly = 3;
        a0 = as_low; u0 = uds_low; l0 = lds_low; u20 = uds2_low; l20 = lds2_low; n20 = n_x2_low;
        push(1'b0, 24'h001234, 4'b1111, 16'h0);
        wait_rsp("t2", 400);
        check("t2_as_low", 32'(as_low - a0), 32'd16);
        check("t2_uds_lds_low", 32'({16'(uds_low - u0), 16'(lds_low - l0)}), 32'h00100010);
        check("t2_x2_low", 32'({16'(uds2_low - u20), 16'(lds2_low - l20)}), 32'h00100010);
        check("t2_narrow_x2_low", 32'(n_x2_low - n20), 32'd0);
        check("t2_r_w", 32'({w_r_w, n_r_w}), 32'h3);
        pop("t2", 32'h12345678, 32'h12340000, 1'b0);

        // Timeout, then a queued write runs normally
        dly = 100;
        a0 = as_low;
        push(1'b0, 24'h000040, 4'b1100, 16'h0);
        push(1'b1, 24'h000042, 4'b1100, 16'hBEEF);
        wait_rsp("t3", 400);
        dly = 0;
        check("t3_as_low", 32'(as_low - a0), 32'd64);
        check("t3_err", 32'({w_err_count, n_err_count}), 32'h0101);
        pop("t3a", 32'h0, 32'h0, 1'b1);
        pop("t3b", 32'h0, 32'h0, 1'b0);
        check("t3_err_after", 32'(w_err_count), 32'd1);

        // DEPTH+1 commands with responses held back
        repeat (4) @(negedge clk_28);
        check("t4_idle", 32'({w_busy, w_rsp_valid}), 32'h0);
        align_tick();
        f0 = as_falls;
        push(1'b0, 24'h000110, 4'b1100, 16'h0);
        push(1'b0, 24'h000211, 4'b1100, 16'h0);
        push(1'b0, 24'h000310, 4'b1100, 16'h0);
        push(1'b0, 24'h000410, 4'b1100, 16'h0);
        check("t4_full", 32'({w_cmd_ready, n_cmd_ready}), 32'h0);
        push(1'b0, 24'h000510, 4'b1100, 16'h0);
        repeat (200) @(negedge clk_28);
        check("t4_cycles_run", 32'(as_falls - f0), 32'd4);
        check("t4_stalled", 32'({w_rsp_valid, w_as, w_busy, w_cmd_ready}), 32'hF);
        pop("t4c0", 32'h01104554, 32'h01100000, 1'b0);
        pop("t4c1", 32'h02104654, 32'h02100000, 1'b0);
        pop("t4c2", 32'h03104754, 32'h03100000, 1'b0);
        pop("t4c3", 32'h04104854, 32'h04100000, 1'b0);
        pop("t4c4", 32'h05104954, 32'h05100000, 1'b0);

        // Reset in the middle of WAIT with work queued on both sides
        dly = 0;
        push(1'b1, 24'h000020, 4'b1100, 16'h1111);
        wait_rsp("t5a", 400);
        dly = 100;
        push(1'b0, 24'h000030, 4'b1111, 16'h0);
        push(1'b0, 24'h000032, 4'b1111, 16'h0);
        n = 0;
        while (w_as && n < 200) begin @(negedge clk_28); n++; end
        repeat (6) @(negedge clk_28);
        check("t5_pre_w", 32'({w_as, w_uds, w_lds, w_uds2, w_lds2}), 32'h00);
        check("t5_pre_n", 32'({n_as, n_uds, n_lds, n_uds2, n_lds2}), 32'h03);
        reset_n = 1'b0;
        #1;
        check("t5_async_w", 32'({w_as, w_uds, w_lds, w_uds2, w_lds2}), 32'h1F);
        check("t5_async_n", 32'({n_as, n_uds, n_lds, n_uds2, n_lds2}), 32'h1F);
        @(negedge clk_28);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_28);
        check("t5_post", 32'({w_busy, n_busy, w_rsp_valid, n_rsp_valid, w_cmd_ready, n_cmd_ready}), 32'h03);
        check("t5_err_cleared", 32'({w_err_count, n_err_count}), 32'h0);

        // 300 timeouts saturate the error counter
        dly = 100;
        rsp_ready = 1'b1;
        for (int i = 0; i < 300; i++) push(1'b0, 24'h000060, 4'b1100, 16'h0);
        n = 0;
        while (w_busy && n < 2000) begin @(negedge clk_28); n++; end
        check("t6_drained", 32'(w_busy), 32'd0);
        repeat (8) @(negedge clk_28);
        check("t6_err_sat", 32'({w_err_count, n_err_count}), 32'hFFFF);
        check("t6_rsp_empty", 32'({w_rsp_valid, n_rsp_valid}), 32'h0);
        rsp_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
